// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM states for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring step for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    assign w_sum    = i_q[0] ? (i_acc + {1'b0, i_m}) : i_acc;
    assign w_rem_sh = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, i_m});
    assign w_diff   = w_rem_sh - {1'b0, i_m};

    always_comb begin
        o_acc = {1'b0, w_sum[WIDTH:1]};
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        if (i_div) begin
            o_acc = w_ge ? w_diff : w_rem_sh;
            o_q   = {i_q[WIDTH-2:0], w_ge};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_is_md;
    logic               w_is_div;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    assign w_accept = start && !busy && !flush;
    assign w_is_md  = (op[2] == 1'b0);
    assign w_is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign w_sgn    = (op == MD_MULT) || (op == MD_DIV);
    assign w_abs_a  = (w_sgn && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_sgn && b[WIDTH-1]) ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_is_div),
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_m   (r_m),
        .o_acc (w_acc_nxt),
        .o_q   (w_q_nxt)
    );

    // Divide-by-zero naturally leaves the dividend as remainder; only LO is forced.
    assign w_prod     = {r_acc[WIDTH-1:0], r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
    assign w_rem      = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept && w_is_md) w_state_nxt = RUN;
            end
            RUN: begin
                if (flush)
                    w_state_nxt = IDLE;
                else if (r_cnt == CNT_W'(WIDTH - 1))
                    w_state_nxt = FIXUP;
            end
            FIXUP:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_is_md) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_q      <= w_is_div ? w_abs_a : w_abs_b;
                        r_m      <= w_is_div ? w_abs_b : w_abs_a;
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r  <= w_sgn && a[WIDTH-1];
                        r_dz     <= w_is_div && (b == '0);
                    end else if (w_accept && op == MD_MTHI) begin
                        r_hi   <= a;
                        r_done <= 1'b1;
                    end else if (w_accept && op == MD_MTLO) begin
                        r_lo   <= a;
                        r_done <= 1'b1;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                end
                FIXUP: begin
                    if (!flush) begin
                        r_hi   <= r_is_div ? w_rem : w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo   <= r_is_div ? w_quo : w_prod_fix[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the combinational ALU in the execute stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. A busy/done handshake lets the pipeline stall MFHI/MFLO and any further mul/div until the result has been committed.

Parameters:
WIDTH, 32, operand width and HI/LO register width (WIDTH >= 4, even).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; accepted only when busy=0 and flush=0.
op  input  3  operation code, from the package: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
b  input  WIDTH  rt operand (divisor / multiplier).
flush  input  1  cancels any in-flight operation.
busy  output  1  operation in flight.
done  output  1  one-cycle pulse: HI/LO were updated at the previous edge.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Counter and datapath registers are 0.
- States: IDLE, RUN, FIXUP.
- Accept:
  - Accept happens at an edge where start=1, busy=0 and flush=0.
  - Operands are latched at the accept edge. Later changes on a/b have no effect.
- MTHI/MTLO:
  - At the accept edge, hi<=a (MTHI) or lo<=a (MTLO).
  - State stays IDLE; busy never rises; done=1 in the following cycle.
- MULT/MULTU/DIV/DIVU:
  - Accept edge: IDLE->RUN, busy=1, counter=0.
  - Signed ops latch the absolute values of the operands and record the result signs.
- RUN:
  - One iteration per cycle: radix-2 shift-add for multiply, radix-2 restoring for divide.
  - The counter increments each cycle.
  - After WIDTH iterations the state goes RUN->FIXUP.
- FIXUP:
  - Applies sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Writes HI/LO, FIXUP->IDLE, busy=0.
  - done=1 for the next cycle only.
- Latency:
  - Accept at edge E0 writes HI/LO at edge E0+WIDTH+1 (33 for WIDTH=32).
  - done is high in the cycle following that edge.
  - busy is high in the cycles between E0 and E0+WIDTH+1.
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH-bit product.
  - Divide: lo = quotient truncated toward zero; hi = remainder.
  - Intermediate arithmetic is WIDTH+1 bits, so the magnitude 2^(WIDTH-1) does not overflow.
- Divide by zero (b=0): normal latency. lo = all-ones, hi = a (unmodified dividend, signed or unsigned).
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = 0x80000000 (WIDTH=32), hi = 0.
- start while busy=1: ignored, including MTHI/MTLO. The pipeline must stall on busy.
- flush:
  - In RUN/FIXUP: go to IDLE at the next edge; busy=0, no done pulse, HI/LO unchanged.
  - flush and start in the same cycle: flush wins, start is ignored.
- HI/LO are never partially updated. While busy, hi/lo show the previous committed values.
- reset_n low mid-operation: immediate return to the reset values; the operation is lost.
- Undefined op code with start: treated as a no-op; no state change, no done.

Decomposition:
- Package muldiv_pkg:
  - typedef md_op_t (3-bit enum): MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - typedef md_state_t: IDLE, RUN, FIXUP.
- Sub-module muldiv_step: combinational single-iteration datapath (add-or-pass for multiply / trial-subtract for divide), parametrised on WIDTH.
- Top level holds the FSM, counter, sign bookkeeping and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulse of exactly 1 cycle.
- MULT a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF then MTLO a=0x5 on consecutive cycles -> hi updated after edge 1, lo after edge 2; busy stays 0; done high for 2 cycles.
- MULTU 7*6, then start MTLO at cycle 5 and assert flush at cycle 10 -> MTLO ignored; no done; hi/lo keep their prior values; a new DIVU 100/7 started next gives lo=14, hi=2.
- reset_n pulled low at cycle 12 of a DIV -> hi=lo=0, busy=0 asynchronously. Also rerun with WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 cycles.
